rate_decoder: RTL and testbench

- Receive-side counterpart of the speed-selectable rate divider.
- Takes the single-cycle enable pulse train the divider produces and measures the spacing between pulses.
- Classifies that period back into the 2-bit speed code and reports lock after two consecutive matching periods.
- Sits downstream of the divider/counter path; used for self-check and for display of the active speed.

---
 rtl/rate_decoder_if.sv | 21 ++
 rtl/rate_decoder.sv | 140 ++++++++++++++
 tb/tb_rate_decoder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rate_decoder_if.sv
// Pulse-train input and decoded-speed outputs of the rate decoder.
interface rate_decoder_if;
   logic       Pulse;
   logic [1:0] SpeedOut;
   logic       Locked;
   logic       Changed;
   logic       Error;
   logic       Timeout;

   // Pulse source and observer side
   modport master (
      output Pulse,
      input  SpeedOut, Locked, Changed, Error, Timeout
   );

   // Decoder side
   modport slave (
      input  Pulse,
      output SpeedOut, Locked, Changed, Error, Timeout
   );
endinterface

// File: rtl/rate_decoder.sv
// Measures the spacing of rate-divider enable pulses, classifies it back into
// the 2-bit speed code and reports lock after two matching periods.
module rate_decoder #(
   parameter int unsigned P1      = 500,
   parameter int unsigned P2      = 1000,
   parameter int unsigned P3      = 2000,
   parameter int unsigned TOL     = 4,
   parameter int unsigned TIMEOUT = 4000,
   parameter int unsigned CW      = 12
) (
   input  logic         ClockIn,
   input  logic         Reset,
   rate_decoder_if.slave bus
);

   localparam int unsigned PW = CW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      CAND  = 2'd2,
      LOCK  = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] gap;
   logic [1:0]    cand;
   logic          was_locked;
   logic [1:0]    speed_q;
   logic          locked_q;
   logic          changed_q;
   logic          error_q;
   logic          timeout_q;

   logic [PW-1:0] per_c;
   logic [1:0]    cls_c;
   logic          cls_ok_c;
   logic          gap_expired_c;

   assign per_c         = PW'(gap) + PW'(1);
   assign gap_expired_c = (gap == CW'(TIMEOUT - 1));

   // Classify the period that ends on the current pulse
   always_comb begin
      cls_c    = 2'b00;
      cls_ok_c = 1'b0;
      if (per_c == PW'(1)) begin
         cls_c    = 2'b00;
         cls_ok_c = 1'b1;
      end else if (per_c >= PW'(P1 - TOL) && per_c <= PW'(P1 + TOL)) begin
         cls_c    = 2'b01;
         cls_ok_c = 1'b1;
      end else if (per_c >= PW'(P2 - TOL) && per_c <= PW'(P2 + TOL)) begin
         cls_c    = 2'b10;
         cls_ok_c = 1'b1;
      end else if (per_c >= PW'(P3 - TOL) && per_c <= PW'(P3 + TOL)) begin
         cls_c    = 2'b11;
         cls_ok_c = 1'b1;
      end
   end

   // Gap counter, lock state machine and registered strobes
   always_ff @(posedge ClockIn or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         gap        <= '0;
         cand       <= 2'b00;
         was_locked <= 1'b0;
         speed_q    <= 2'b00;
         locked_q   <= 1'b0;
         changed_q  <= 1'b0;
         error_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         changed_q <= 1'b0;
         error_q   <= 1'b0;
         timeout_q <= 1'b0;

         if (state == IDLE || bus.Pulse) begin
            gap <= '0;
         end else if (gap != '1) begin
            gap <= gap + CW'(1);
         end

         if (bus.Pulse) begin
            case (state)
               IDLE: state <= ARMED;
               ARMED: begin
                  if (cls_ok_c) begin
                     state      <= CAND;
                     cand       <= cls_c;
                     was_locked <= 1'b0;
                  end else begin
                     error_q <= 1'b1;
                  end
               end
               CAND: begin
                  if (cls_ok_c && cls_c == cand) begin
                     state     <= LOCK;
                     speed_q   <= cand;
                     locked_q  <= 1'b1;
                     changed_q <= (cand != speed_q) || !was_locked;
                  end else if (cls_ok_c) begin
                     cand <= cls_c;
                  end else begin
                     state   <= ARMED;
                     error_q <= 1'b1;
                  end
               end
               LOCK: begin
                  if (cls_ok_c && cls_c != speed_q) begin
                     state      <= CAND;
                     cand       <= cls_c;
                     locked_q   <= 1'b0;
                     was_locked <= 1'b1;
                  end else if (!cls_ok_c) begin
                     state    <= ARMED;
                     locked_q <= 1'b0;
                     error_q  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE && gap_expired_c) begin
            // Pulse train lost: drop lock but keep the last displayed speed
            state     <= IDLE;
            gap       <= '0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b1;
         end
      end
   end

   assign bus.SpeedOut = speed_q;
   assign bus.Locked   = locked_q;
   assign bus.Changed  = changed_q;
   assign bus.Error    = error_q;
   assign bus.Timeout  = timeout_q;

endmodule

// File: tb/tb_rate_decoder.sv
// Bench for rate_decoder: directed and random pulse trains against a
// period-history reference model.
module tb_rate_decoder;

   localparam int P1      = 500;
   localparam int P2      = 1000;
   localparam int P3      = 2000;
   localparam int TOL     = 4;
   localparam int TIMEOUT = 4000;

   logic ClockIn = 1'b0;
   logic Reset;

   rate_decoder_if bus ();

   rate_decoder dut (
      .ClockIn (ClockIn),
      .Reset   (Reset),
      .bus     (bus)
   );

   always #5 ClockIn = ~ClockIn;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: periods classified since the train was (re)acquired
   longint cyc        = 0;
   longint last_pulse = 0;
   bit     m_armed    = 0;
   bit     m_ever     = 0;
   int     hist[$];
   int     m_speed    = 0;
   bit     m_locked   = 0;
   bit     m_changed  = 0;
   bit     m_error    = 0;
   bit     m_timeout  = 0;

   function automatic int classify(input int per);
      if (per == 1) return 0;
      if (per >= P1 - TOL && per <= P1 + TOL) return 1;
      if (per >= P2 - TOL && per <= P2 + TOL) return 2;
      if (per >= P3 - TOL && per <= P3 + TOL) return 3;
      return -1;
   endfunction

   task automatic model_reset();
      m_armed = 0; m_ever = 0; hist.delete();
      m_speed = 0; m_locked = 0; m_changed = 0; m_error = 0; m_timeout = 0;
   endtask

   task automatic model_edge(input bit p);
      int  code;
      bit  now_locked;
      cyc++;
      m_changed = 0; m_error = 0; m_timeout = 0;
      if (p) begin
         if (!m_armed) begin
            m_armed = 1; m_ever = 0; hist.delete();
         end else begin
            code = classify(int'(cyc - last_pulse));
            if (code < 0) begin
               m_error = 1; m_ever = 0; m_locked = 0; hist.delete();
            end else begin
               hist.push_back(code);
               if (hist.size() > 2) void'(hist.pop_front());
               now_locked = (hist.size() == 2) && (hist[0] == hist[1]);
               if (now_locked && !m_locked) begin
                  m_changed = !m_ever || (code != m_speed);
                  m_speed   = code;
                  m_ever    = 1;
               end
               m_locked = now_locked;
            end
         end
         last_pulse = cyc;
      end else if (m_armed && (cyc - last_pulse) == TIMEOUT) begin
         m_timeout = 1; m_armed = 0; m_locked = 0;
      end
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_model();
      check("speed",   4'(bus.SpeedOut), 4'(m_speed));
      check("locked",  4'(bus.Locked),   4'(m_locked));
      check("changed", 4'(bus.Changed),  4'(m_changed));
      check("error",   4'(bus.Error),    4'(m_error));
      check("timeout", 4'(bus.Timeout),  4'(m_timeout));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_speed"},   4'(bus.SpeedOut), 4'h0);
      check({tag, "_locked"},  4'(bus.Locked),   4'h0);
      check({tag, "_changed"}, 4'(bus.Changed),  4'h0);
      check({tag, "_error"},   4'(bus.Error),    4'h0);
      check({tag, "_timeout"}, 4'(bus.Timeout),  4'h0);
   endtask

   // One clock: drive on the falling edge, update model at the rising edge, compare 1 ns later
   task automatic tick(input bit p);
      @(negedge ClockIn);
      bus.Pulse = p;
      @(posedge ClockIn);
      model_edge(p);
      #1 check_model();
   endtask

   // n further pulses, each per cycles after the previous one
   task automatic train(input int per, input int n);
      for (int k = 0; k < n; k++) begin
         repeat (per - 1) tick(1'b0);
         tick(1'b1);
      end
   endtask

   task automatic do_reset();
      @(negedge ClockIn);
      bus.Pulse = 1'b0;
      Reset = 1'b0;
      model_reset();
      #1 check_zero("rst");
      @(negedge ClockIn);
      Reset = 1'b1;
   endtask

   initial begin
      int per;
      int sel;
      Reset     = 1'b0;
      bus.Pulse = 1'b0;
      repeat (3) @(negedge ClockIn);
      check_zero("por");
      Reset = 1'b1;

      // Continuous pulses lock onto code 00
      repeat (8) tick(1'b1);
      check("cont_locked", 4'(bus.Locked), 4'h1);
      check("cont_speed",  4'(bus.SpeedOut), 4'h0);
      repeat (3) tick(1'b0);

      // Code 01, then switch to code 10
      do_reset();
      tick(1'b1);
      train(P1, 2);
      check("p1_locked", 4'(bus.Locked), 4'h1);
      check("p1_changed", 4'(bus.Changed), 4'h1);
      check("p1_speed", 4'(bus.SpeedOut), 4'h1);
      train(P2, 1);
      check("p2_drop", 4'(bus.Locked), 4'h0);
      train(P2, 1);
      check("p2_speed", 4'(bus.SpeedOut), 4'h2);
      check("p2_changed", 4'(bus.Changed), 4'h1);

      // Code 11 with tolerance edges, then one cycle beyond
      do_reset();
      tick(1'b1);
      train(P3, 2);
      train(P3 + TOL, 1);
      train(P3 - TOL, 1);
      check("p3_tol_locked", 4'(bus.Locked), 4'h1);
      train(P3 + TOL + 1, 1);
      check("p3_over_error", 4'(bus.Error), 4'h1);
      check("p3_over_locked", 4'(bus.Locked), 4'h0);

      // Lock on 10, then silence until timeout
      do_reset();
      tick(1'b1);
      train(P2, 2);
      repeat (TIMEOUT - 1) tick(1'b0);
      check("to_early", 4'(bus.Timeout), 4'h0);
      tick(1'b0);
      check("to_fire", 4'(bus.Timeout), 4'h1);
      check("to_speed", 4'(bus.SpeedOut), 4'h2);
      repeat (10) tick(1'b0);
      tick(1'b1);
      check("to_rearm_err", 4'(bus.Error), 4'h0);

      // Period between codes never locks
      do_reset();
      tick(1'b1);
      train(750, 4);
      check("mid_locked", 4'(bus.Locked), 4'h0);

      // Asynchronous reset in the middle of a period
      do_reset();
      tick(1'b1);
      train(P1, 2);
      repeat (200) tick(1'b0);
      #2 Reset = 1'b0;
      bus.Pulse = 1'b0;
      model_reset();
      #1 check_zero("async");
      @(negedge ClockIn);
      Reset = 1'b1;
      tick(1'b1);
      train(P1, 1);
      check("relock_early", 4'(bus.Locked), 4'h0);
      train(P1, 1);
      check("relock", 4'(bus.Locked), 4'h1);

      // Random periods around and between the code windows
      do_reset();
      tick(1'b1);
      for (int i = 0; i < 20; i++) begin
         sel = int'($urandom_range(0, 6));
         case (sel)
            0: per = 1;
            1: per = P1 + int'($urandom_range(0, 12)) - 6;
            2: per = P2 + int'($urandom_range(0, 12)) - 6;
            3: per = P2 + int'($urandom_range(0, 12)) - 6;
            4: per = P3 + int'($urandom_range(0, 12)) - 6;
            5: per = P1 + int'($urandom_range(0, 8)) - 4;
            default: per = int'($urandom_range(2, 1200));
         endcase
         train(per, 1 + int'($urandom_range(0, 1)));
      end
      repeat (TIMEOUT + 5) tick(1'b0);
      tick(1'b1);
      train(P2, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
